// File: rtl/dm_lane_mem_pkg.sv
// Shared encodings for the lane-aware data memory: access sizes, FSM states
// and the latency counter width.
package dm_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dm_lane_mem_if.sv
// Request/response bus between the EX/MEM stage (master) and the data memory (slave).
interface dm_lane_mem_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dm_lane_mem_lane_unit.sv
// Combinational byte-lane logic: merges sub-word stores into the old word and
// extracts/extends sub-word loads; flags illegal sizes and misaligned lanes.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_merged,
  output logic [31:0] o_load,
  output logic        o_misalign
);

  logic [4:0]  w_bpos;
  logic [4:0]  w_hpos;
  logic [31:0] w_bsh;
  logic [31:0] w_hsh;

  assign w_bpos = {i_lane, 3'b000};
  assign w_hpos = {i_lane[1], 4'b0000};
  assign w_bsh  = i_old >> w_bpos;
  assign w_hsh  = i_old >> w_hpos;

  always_comb begin
    o_merged   = i_old;
    o_load     = '0;
    o_misalign = 1'b0;
    case (i_size)
      SIZE_B: begin
        o_merged[w_bpos +: 8] = i_wdata[7:0];
        o_load = i_sign ? {{24{w_bsh[7]}}, w_bsh[7:0]} : {24'd0, w_bsh[7:0]};
      end
      SIZE_H: begin
        o_merged[w_hpos +: 16] = i_wdata[15:0];
        o_load     = i_sign ? {{16{w_hsh[15]}}, w_hsh[15:0]} : {16'd0, w_hsh[15:0]};
        o_misalign = i_lane[0];
      end
      SIZE_W: begin
        o_merged   = i_wdata;
        o_load     = i_old;
        o_misalign = |i_lane;
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_lane_mem.sv
// Data memory with byte/half/word access, fault reporting and a fixed-latency
// valid/ready request port; one request in flight at a time.
module dm_lane_mem
  import dm_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int LOG_EN  = 1
) (
  input  logic         clk,
  input  logic         reset,
  dm_lane_mem_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  state_t           r_state;
  logic [LAT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_resp_valid;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_sign;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_pc;

  logic             w_idle;
  logic             w_we;
  logic [1:0]       w_size;
  logic             w_sign;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic [31:0]      w_pc;
  logic [AW-1:0]    w_idx;
  logic             w_range_err;
  logic             w_misalign;
  logic             w_err;
  logic             w_commit;
  logic [31:0]      w_merged;
  logic [31:0]      w_load;

  // With zero latency the access commits on the accept edge, before the
  // latch registers hold the request, so the live bus is used instead.
  assign w_idle  = (r_state == IDLE);
  assign w_we    = w_idle ? bus.req_we    : r_we;
  assign w_size  = w_idle ? bus.req_size  : r_size;
  assign w_sign  = w_idle ? bus.req_sign  : r_sign;
  assign w_addr  = w_idle ? bus.req_addr  : r_addr;
  assign w_wdata = w_idle ? bus.req_wdata : r_wdata;
  assign w_pc    = w_idle ? bus.req_pc    : r_pc;

  assign w_idx       = w_addr[AW+1:2];
  assign w_range_err = |(w_addr >> (AW + 2));
  assign w_err       = w_misalign | w_range_err;
  assign w_commit    = (w_idle && bus.req_valid && (LATENCY == 0)) ||
                       ((r_state == WAIT) && (r_cnt == LAT_W'(1)));

  dm_lane_unit u_lane (
    .i_old      (r_mem[w_idx]),
    .i_wdata    (w_wdata),
    .i_size     (w_size),
    .i_sign     (w_sign),
    .i_lane     (w_addr[1:0]),
    .o_merged   (w_merged),
    .o_load     (w_load),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_we    <= bus.req_we;
          r_size  <= bus.req_size;
          r_sign  <= bus.req_sign;
          r_addr  <= bus.req_addr;
          r_wdata <= bus.req_wdata;
          r_pc    <= bus.req_pc;
          r_cnt   <= LAT_W'(LATENCY);
          r_ready <= 1'b0;
          r_state <= (LATENCY == 0) ? RESP : WAIT;
        end
        WAIT: begin
          if (r_cnt == LAT_W'(1)) r_state <= RESP;
          else                    r_cnt   <= r_cnt - LAT_W'(1);
        end
        RESP: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_commit) begin
        r_resp_valid <= 1'b1;
        r_err        <= w_err;
        r_rdata      <= (w_we || w_err) ? 32'd0 : w_load;
        if (w_we && !w_err) r_mem[w_idx] <= w_merged;
      end
    end
  end

  generate
    if (LOG_EN != 0) begin : g_log
      always_ff @(posedge clk) begin
        if (reset && w_commit && w_we && !w_err)
          $display("@%h: *%h <= %h", w_pc, {w_addr[31:2], 2'b00}, w_merged);
      end
    end
  endgenerate

  assign bus.req_ready  = r_ready & reset;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_dm_lane_mem.sv
// Randomized and directed bench for dm_lane_mem against a byte-addressed model;
// one instance at LATENCY=2 and one at LATENCY=0.
module tb_dm_lane_mem;
  import dm_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_lane_mem_if ifa ();
  dm_lane_mem_if ifb ();

  dm_lane_mem #(.DEPTH(DEPTH), .LATENCY(2), .LOG_EN(1)) u_dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  dm_lane_mem #(.DEPTH(DEPTH), .LATENCY(0), .LOG_EN(0)) u_dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int lat [2] = '{2, 0};
  logic [7:0]  m_mem [2][DEPTH*4];
  logic [31:0] pc = 32'h0040_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Reference: memory as a flat little-endian byte array.
  function automatic void model(input int d, input logic we, input logic [1:0] size,
                                input logic sign, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    int n;
    logic [31:0] nn;
    n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    nn = 32'(n);
    err = (size == 2'd3) || ((addr % nn) != 0) || (addr >= 32'(DEPTH * 4));
    rdata = '0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < n; k++) m_mem[d][addr + 32'(k)] = wdata[8*k +: 8];
      end else begin
        for (int k = 0; k < n; k++) rdata |= 32'(m_mem[d][addr + 32'(k)]) << (8 * k);
        if (sign && n < 4 && rdata[8*n-1]) rdata |= 32'hFFFF_FFFF << (8 * n);
      end
    end
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH * 4; i++) m_mem[d][i] = 8'h00;
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? ifa.req_ready : ifb.req_ready;
  endfunction
  function automatic logic rv(input int d);
    return (d == 0) ? ifa.resp_valid : ifb.resp_valid;
  endfunction
  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? ifa.resp_rdata : ifb.resp_rdata;
  endfunction
  function automatic logic rerr(input int d);
    return (d == 0) ? ifa.resp_err : ifb.resp_err;
  endfunction

  task automatic set_req(input int d, input logic v, input logic we, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr, input logic [31:0] wdata);
    pc = pc + 32'd4;
    if (d == 0) begin
      ifa.req_valid = v; ifa.req_we = we; ifa.req_size = size; ifa.req_sign = sign;
      ifa.req_addr = addr; ifa.req_wdata = wdata; ifa.req_pc = pc;
    end else begin
      ifb.req_valid = v; ifb.req_we = we; ifb.req_size = size; ifb.req_sign = sign;
      ifb.req_addr = addr; ifb.req_wdata = wdata; ifb.req_pc = pc;
    end
  endtask

  task automatic xact(input int d, input logic we, input logic [1:0] size, input logic sign,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd);
    logic [31:0] erd;
    logic        eerr;
    int          n;
    @(negedge clk);
    chk($sformatf("ready_d%0d", d), 32'(rdy(d)), 32'd1);
    set_req(d, 1'b1, we, size, sign, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    set_req(d, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    model(d, we, size, sign, addr, wdata, erd, eerr);
    n = 1;
    while (!rv(d) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("latency_d%0d_a%h", d, addr), 32'(n), 32'(lat[d] + 1));
    chk($sformatf("err_d%0d_a%h", d, addr), 32'(rerr(d)), 32'(eerr));
    chk($sformatf("rdata_d%0d_a%h", d, addr), rdat(d), erd);
    rd = rdat(d);
    @(negedge clk);
    chk($sformatf("pulse_d%0d", d), 32'(rv(d)), 32'd0);
  endtask

  task automatic throughput(input int d);
    logic [31:0] erd;
    logic        eerr;
    int acc = 0, resps = 0, last = -1, p;
    p = lat[d] + 2;
    model(d, 1'b0, SIZE_W, 1'b0, 32'h10, 32'd0, erd, eerr);
    @(negedge clk);
    set_req(d, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h10, 32'd0);
    for (int i = 0; i < 30; i++) begin
      if (rv(d)) begin
        resps++;
        chk($sformatf("thr_rdata_d%0d", d), rdat(d), erd);
      end
      if (rdy(d)) begin
        acc++;
        if (last >= 0) chk($sformatf("thr_gap_d%0d", d), 32'(i - last), 32'(p));
        last = i;
      end
      @(negedge clk);
    end
    set_req(d, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < p + 2; i++) begin
      if (rv(d)) resps++;
      @(negedge clk);
    end
    chk($sformatf("thr_accepts_d%0d", d), 32'(acc), 32'((30 + p - 1) / p));
    chk($sformatf("thr_resps_d%0d", d), 32'(resps), 32'(acc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [1:0]  sz;
    int          seen;

    reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_ready_low", 32'(ifa.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(ifa.resp_valid), 32'd0);
    chk("rst_resp_rdata", ifa.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(ifa.resp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", 32'(ifa.req_ready), 32'd1);

    // Directed word / byte / half sequence
    xact(0, 1'b1, SIZE_W, 1'b0, 32'h10, 32'h1234_5678, rd);
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'd0, rd); chk("lw10", rd, 32'h1234_5678);
    xact(0, 1'b1, SIZE_B, 1'b0, 32'h13, 32'h0000_00AB, rd);
    xact(0, 1'b0, SIZE_B, 1'b1, 32'h13, 32'd0, rd); chk("lb13", rd, 32'hFFFF_FFAB);
    xact(0, 1'b0, SIZE_B, 1'b0, 32'h13, 32'd0, rd); chk("lbu13", rd, 32'h0000_00AB);
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'd0, rd); chk("lw10_b", rd, 32'hAB34_5678);
    xact(0, 1'b1, SIZE_H, 1'b0, 32'h22, 32'h0000_8001, rd);
    xact(0, 1'b0, SIZE_H, 1'b1, 32'h22, 32'd0, rd); chk("lh22", rd, 32'hFFFF_8001);
    xact(0, 1'b0, SIZE_H, 1'b0, 32'h22, 32'd0, rd); chk("lhu22", rd, 32'h0000_8001);
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h20, 32'd0, rd); chk("lw20", rd, 32'h8001_0000);

    // Faults leave memory untouched
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h11, 32'd0, rd);
    xact(0, 1'b1, SIZE_H, 1'b0, 32'h21, 32'hDEAD_BEEF, rd);
    xact(0, 1'b1, SIZE_X, 1'b0, 32'h20, 32'hDEAD_BEEF, rd);
    xact(0, 1'b1, SIZE_W, 1'b0, 32'h1000, 32'hDEAD_BEEF, rd);
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h20, 32'd0, rd); chk("lw20_after_faults", rd, 32'h8001_0000);
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'd0, rd); chk("lw10_after_faults", rd, 32'hAB34_5678);

    // Back-to-back handshake at both latencies
    xact(1, 1'b1, SIZE_W, 1'b0, 32'h10, 32'hCAFE_F00D, rd);
    throughput(0);
    throughput(1);

    // Randomized traffic, mostly in a small window so stores and loads collide
    for (int i = 0; i < 160; i++) begin
      int d;
      d  = (i % 4 == 3) ? 1 : 0;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom();
      else                           a = 32'($urandom_range(0, 63));
      xact(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), rd);
    end

    // Reset while a store is waiting
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, SIZE_W, 1'b0, 32'h30, 32'h5555_AAAA);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ifa.resp_valid) seen++;
      chk("midrst_ready_low", 32'(ifa.req_ready), 32'd0);
    end
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ifa.resp_valid) seen++;
    end
    chk("midrst_no_resp", 32'(seen), 32'd0);
    chk("midrst_ready", 32'(ifa.req_ready), 32'd1);
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h30, 32'd0, rd); chk("midrst_lw30", rd, 32'd0);
    xact(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'd0, rd); chk("midrst_lw10", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dm_lane_mem.md
Name: dm_lane_mem

Overview:
- Parametrised data memory for the MIPS datapath; successor to the word-only DM.
- Adds byte/halfword stores, sign/zero-extended sub-word loads, misalignment/range error reporting, and a valid/ready request port with a configurable fixed access latency.
- Sits between the EX/MEM stage and the CPU's stall logic. Single outstanding request.

Parameters:
DEPTH, 1024, memory depth in 32-bit words; power of two, minimum 4.
LATENCY, 2, wait cycles between accept and response; 0..7.
LOG_EN, 1, 1 = print a store log line on every committed write.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_sign  in  1  load sign-extends when 1; ignored for stores
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_pc  in  32  PC of the issuing instruction, used for logging
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  access faulted; valid only with resp_valid

Behaviour:
- Reset:
  - Reset is sampled at posedge clk while low.
  - All DEPTH words clear to 0 and the FSM goes to IDLE.
  - resp_valid, resp_rdata and resp_err go to 0.
  - req_ready is forced to 0 while reset is low.
  - An in-flight request is dropped: no write, no response.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch we/size/sign/addr/wdata/pc, load cnt=LATENCY, and go to WAIT (or straight to RESP if LATENCY=0).
  - WAIT: req_ready=0. cnt decrements each cycle. When cnt reaches 1, go to RESP.
  - RESP: req_ready=0. resp_valid=1 for exactly one cycle, then return to IDLE.
- Timing: a request accepted at edge T gives resp_valid high during cycle T+1+LATENCY.
  - The store commits on the edge that enters RESP.
  - Load data is read on that same edge.
  - Peak throughput is one request per LATENCY+2 cycles.
- req_* inputs are don't-care outside IDLE. There is no response back-pressure.
- Word index is addr[clog2(DEPTH)+1:2]. Lane is addr[1:0].
- Error conditions (resp_err=1, memory unchanged, resp_rdata=0):
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:clog2(DEPTH)+2] != 0.
- Store merge:
  - byte writes wdata[7:0] into lane addr[1:0];
  - half writes wdata[15:0] into bytes addr[1]*2 and addr[1]*2+1;
  - word writes the full word;
  - unselected bytes are preserved.
- Load extract: the selected byte/half is shifted to bit 0, then sign-extended if req_sign, else zero-extended. Word loads ignore req_sign.
- Store log: on commit with LOG_EN=1, print "@%h: *%h <= %h" with the latched PC, the word-aligned address, and the merged 32-bit word. Faulting stores print nothing.
- A load to a word stored by the previous request returns the new data, since both happen at the RESP-entry edge in separate transactions.

Decomposition:
- Package dm_pkg:
  - SIZE_B/SIZE_H/SIZE_W/SIZE_X encodings;
  - state enum IDLE/WAIT/RESP;
  - LAT_W=3 counter width.
- Sub-module dm_lane_unit (combinational). Inputs: old word, wdata, size, sign, addr[1:0]. Outputs: merged store word, extended load word, misalign flag.
- Top module holds the FSM, the latch registers, the array and the range check.

Test Plan:
- Word store/load, LATENCY=2:
  - store addr=0x10 wdata=0x12345678 gives resp_valid at cycle T+3, err=0, and the log line "*00000010 <= 12345678";
  - a later word load of 0x10 returns 0x12345678.
- Byte lanes: after the above, sb addr=0x13 wdata=0xAB then lb 0x13 returns 0xFFFFFFAB, lbu 0x13 returns 0x000000AB, and lw 0x10 returns 0xAB345678.
- Halfword: sh addr=0x22 wdata=0x00008001; lh 0x22 returns 0xFFFF8001, lhu returns 0x00008001, lw 0x20 returns 0x80010000.
- Faults:
  - lw 0x11, sh 0x21, size=11 and sw 0x1000 (DEPTH=1024) each give err=1 and rdata=0;
  - memory is unchanged and no log line is printed.
- Handshake: req_valid held high continuously while req_ready=0 gives exactly one accept per LATENCY+2 cycles; repeat with LATENCY=0 (response at T+1).
- Reset mid-op: accept sw 0x30, pull reset low during WAIT. Required response:
  - no resp_valid and no log line;
  - after release, req_ready=1 and lw 0x30 returns 0.
